// File: rtl/cdb_tx_queue.sv
`default_nettype none
// ============================================================================
// Module  : cdb_tx_queue
// Purpose : Result FIFO that requests the common data bus. It pops its head
//           entry when it sees that entry's tag broadcast on the bus.
//           Optional starvation flag: define CDB_TX_STARVE_EN.
// Revision: 1.0  initial release
// ============================================================================

`ifndef CDB_TAG_FIELD
`define CDB_TAG_FIELD (TAG_W+DATA_W-1):DATA_W
`endif
`ifndef CDB_DATA_FIELD
`define CDB_DATA_FIELD (DATA_W-1):0
`endif

module cdb_tx_queue #(
  parameter int DEPTH        = 4,
  parameter int TAG_W        = 8,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       res_valid,
  output logic                       res_ready,
  input  logic [TAG_W-1:0]           res_tag,
  input  logic [DATA_W-1:0]          res_data,
  output logic                       cdb_request,
  output logic [TAG_W+DATA_W-1:0]    cdb_out,
  input  logic [TAG_W+DATA_W:0]      cdb,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       tag_err
`ifdef CDB_TX_STARVE_EN
  ,
  output logic                       starve
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = TAG_W + DATA_W;
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             tag_err_q, tag_err_d;

  logic             w_full, w_empty, w_push, w_pop;
  logic [ENT_W-1:0] w_head;
  logic             w_unused_cdb_data;

  assign w_full  = (count_q == C_DEPTH);
  assign w_empty = (count_q == '0);
  assign w_head  = mem_q[rptr_q];

  // Grant is inferred from the broadcast: only the tag identifies the entry.
  assign w_push = res_valid & ~w_full & (res_tag != '0);
  assign w_pop  = cdb[ENT_W] & ~w_empty &
                  (cdb[`CDB_TAG_FIELD] == w_head[ENT_W-1:DATA_W]);
  assign w_unused_cdb_data = ^cdb[`CDB_DATA_FIELD];

  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    tag_err_d = res_valid & (res_tag == '0);
    if (w_push) wptr_d = wptr_q + PTR_W'(1);
    if (w_pop)  rptr_d = rptr_q + PTR_W'(1);
    case ({w_push, w_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      tag_err_q <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      tag_err_q <= tag_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) mem_q[wptr_q] <= {res_tag, res_data};
  end

  assign res_ready   = ~w_full;
  assign cdb_request = ~w_empty;
  assign cdb_out     = w_empty ? '0 : w_head;
  assign count       = count_q;
  assign tag_err     = tag_err_q;

`ifdef CDB_TX_STARVE_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] C_STARVE_LIMIT = SW'(STARVE_LIMIT);

  logic [SW-1:0] wait_q, wait_d;

  always_comb begin
    wait_d = wait_q;
    if (w_pop || w_empty)              wait_d = '0;
    else if (wait_q != C_STARVE_LIMIT) wait_d = wait_q + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) wait_q <= '0;
    else     wait_q <= wait_d;
  end

  assign starve = (wait_q == C_STARVE_LIMIT);
`endif

endmodule

`default_nettype wire

// File: tb/tb_cdb_tx_queue.sv
`default_nettype none
// ============================================================================
// Module  : tb_cdb_tx_queue
// Purpose : Scoreboard bench for cdb_tx_queue (FIFO order, grant snooping).
// Revision: 1.0  initial release
// ============================================================================
module tb_cdb_tx_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        res_valid;
  logic [7:0]  res_tag;
  logic [31:0] res_data;
  logic [40:0] cdb;
  wire         res_ready;
  wire         cdb_request;
  wire  [39:0] cdb_out;
  wire  [2:0]  count;
  wire         tag_err;
`ifdef CDB_TX_STARVE_EN
  wire         starve;
  int          wait_m = 0;
`endif

  logic [39:0] sb[$];
  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  cdb_tx_queue #(
    .DEPTH(4), .TAG_W(8), .DATA_W(32)
`ifdef CDB_TX_STARVE_EN
    , .STARVE_LIMIT(2)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_tag(res_tag), .res_data(res_data),
    .cdb_request(cdb_request), .cdb_out(cdb_out), .cdb(cdb),
    .count(count), .tag_err(tag_err)
`ifdef CDB_TX_STARVE_EN
    , .starve(starve)
`endif
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    res_valid = 1'b0;
    res_tag   = 8'h00;
    res_data  = 32'h0;
    cdb       = 41'h0;
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, ".count"}, 64'(count), 64'(sb.size()));
    check_eq({tag, ".req"}, 64'(cdb_request), 64'(sb.size() != 0));
    check_eq({tag, ".out"}, 64'(cdb_out), (sb.size() != 0) ? 64'(sb[0]) : 64'h0);
    check_eq({tag, ".ready"}, 64'(res_ready), 64'(sb.size() < 4));
  endtask

  // One clock: optional push and optional broadcast, then compare against the model.
  task automatic drive(input string tag, input bit pv, input logic [7:0] t, input logic [31:0] d,
                       input bit gv, input logic [39:0] gval);
    bit pop_exp, push_exp, err_exp;
    int pre;
    pre      = sb.size();
    pop_exp  = gv && (pre != 0) && (gval[39:32] == sb[0][39:32]);
    push_exp = pv && (pre < 4) && (t != 8'h00);
    err_exp  = pv && (t == 8'h00);
    res_valid = pv;
    res_tag   = t;
    res_data  = d;
    cdb       = gv ? {1'b1, gval} : 41'h0;
    step();
    idle_inputs();
    if (pop_exp)  void'(sb.pop_front());
    if (push_exp) sb.push_back({t, d});
`ifdef CDB_TX_STARVE_EN
    if (pre == 0 || pop_exp) wait_m = 0;
    else if (wait_m < 2)     wait_m++;
    check_eq({tag, ".starve"}, 64'(starve), 64'(wait_m == 2));
`endif
    check_state(tag);
    check_eq({tag, ".tag_err"}, 64'(tag_err), 64'(err_exp));
  endtask

  task automatic push(input string tag, input logic [7:0] t, input logic [31:0] d);
    drive(tag, 1'b1, t, d, 1'b0, 40'h0);
  endtask

  task automatic grant_head(input string tag);
    logic [39:0] h;
    h = (sb.size() != 0) ? sb[0] : 40'h0;
    drive(tag, 1'b0, 8'h00, 32'h0, 1'b1, h);
  endtask

  task automatic apply_reset(input string tag);
    rst = 1'b1;
    res_valid = 1'b1;
    res_tag   = 8'h55;
    res_data  = 32'h1;
    for (int i = 0; i < 2; i++) begin
      step();
      check_eq({tag, ".count"}, 64'(count), 64'h0);
      check_eq({tag, ".req"}, 64'(cdb_request), 64'h0);
      check_eq({tag, ".out"}, 64'(cdb_out), 64'h0);
      check_eq({tag, ".ready"}, 64'(res_ready), 64'h1);
      check_eq({tag, ".tag_err"}, 64'(tag_err), 64'h0);
    end
    rst = 1'b0;
    idle_inputs();
    sb.delete();
`ifdef CDB_TX_STARVE_EN
    wait_m = 0;
    check_eq({tag, ".starve"}, 64'(starve), 64'h0);
`endif
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    step();
    apply_reset("reset");

    // Single result and its grant
    push("single.push", 8'h81, 32'h48);
    check_eq("single.lit", 64'(cdb_out), 64'h81_0000_0048);
    drive("single.grant", 1'b0, 8'h00, 32'h0, 1'b1, 40'h81_0000_0048);

    // Losing arbitration three times, then winning
    push("arb.push", 8'h82, 32'hBEEF);
    for (int i = 0; i < 3; i++)
      drive("arb.lose", 1'b0, 8'h00, 32'h0, 1'b1, {8'h84, 32'h1234});
    grant_head("arb.win");

    // Fill, overflow attempt, wrap with held producer
    push("fill.p81", 8'h81, 32'h10);
    push("fill.p82", 8'h82, 32'h20);
    push("fill.p84", 8'h84, 32'h30);
    push("fill.p88", 8'h88, 32'h40);
    push("fill.over", 8'h90, 32'h50);
    drive("fill.full_pop", 1'b1, 8'h90, 32'h50, 1'b1, sb[0]);
    drive("fill.wrap", 1'b1, 8'h90, 32'h50, 1'b1, sb[0]);
    for (int i = 0; i < 3; i++) grant_head("fill.drain");

    // Simultaneous push and pop at count 2
    push("sim.pB1", 8'hB1, 32'h1);
    push("sim.pB2", 8'hB2, 32'h2);
    drive("sim.both", 1'b1, 8'hA1, 32'hA1A1, 1'b1, sb[0]);
    grant_head("sim.g1");
    check_eq("sim.tail", 64'(cdb_out[39:32]), 64'hA1);
    grant_head("sim.g2");

    // Illegal tag with one entry live
    push("err.pC1", 8'hC1, 32'hC);
    push("err.zero", 8'h00, 32'hFF);
    drive("err.after", 1'b0, 8'h00, 32'h0, 1'b0, 40'h0);
    grant_head("err.drain");

    // Push into empty queue with a matching broadcast in the same cycle
    drive("empty.both", 1'b1, 8'hD1, 32'hD, 1'b1, {8'hD1, 32'hD});
    grant_head("empty.drain");

    // Reset mid-operation
    push("mid.p1", 8'hE1, 32'h1);
    push("mid.p2", 8'hE2, 32'h2);
    apply_reset("mid.reset");
    drive("mid.idle", 1'b0, 8'h00, 32'h0, 1'b1, {8'hE1, 32'h1});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
